mdivider_prog: RTL and testbench
================================

Name: mdivider_prog

Overview:
Runtime-programmable successor to the fixed-period pulse divider. It counts system clocks modulo a period that is loaded at run time, and drives a registered pulse train on clk_out with a parametrised high time. It supports periodic and one-shot modes, an end-of-period strobe for chaining, and a pulse counter. It sits between the system clock and tick consumers such as sound tone generators, LED sequencers and baud/timer chains.

Parameters:
WIDTH, 24, width of period counter and period registers
M_DEFAULT, `T_100ms (1200000), period in clk cycles after reset
PW, 1, pulse high time in clk cycles (>=1)
CW, 16, width of pulse counter

Ports:
clk  in  1  system clock (12 MHz on iceStick)
rstn  in  1  asynchronous, active-low reset
en  in  1  level; 1 = run, 0 = stop and clear counter
oneshot  in  1  sampled on IDLE->RUN; 1 = single period then DONE
load  in  1  1-cycle strobe: capture period_in
period_in  in  WIDTH  new period in clk cycles
clk_out  out  1  registered pulse output
wrap  out  1  registered strobe, high during the last cycle of each period
done  out  1  high while in DONE (one-shot finished)
pulses  out  CW  number of completed periods since leaving IDLE, wraps modulo 2^CW

Behaviour:
- Reset (rstn=0, async): state=IDLE; cnt=0; per_act=per_shd=M_DEFAULT; clk_out=0, wrap=0, done=0, pulses=0; mode latch=0.
- Period clamp: a loaded value <2 is stored as 2. pw_eff = min(PW, per_act-1), so every period contains at least 1 low cycle.
- States: IDLE, RUN, DONE. en=0 in any state -> IDLE next cycle, cnt=0, all outputs 0. pulses is cleared on entry to IDLE.
- IDLE & en=1 -> RUN, with cnt=0 and clk_out=1 registered on the same edge. The first pulse is therefore visible 1 cycle after en is sampled high. The mode latch captures oneshot on this edge.
- RUN, each cycle:
  - clk_out = (cnt_next < pw_eff).
  - wrap = (cnt_next == per_act-1).
  - If cnt==per_act-1: cnt->0, per_act<=per_shd, pulses+1.
  - Otherwise cnt+1.
- One-shot: at the first wrap, RUN->DONE; clk_out=0, done=1, cnt held at 0. DONE holds until en=0.
- Load:
  - In IDLE or DONE: writes both per_shd and per_act.
  - In RUN: writes per_shd only; takes effect at the next wrap. Running periods are never truncated or glitched.
  - Load coinciding with the wrap cycle: the new value is bypassed into per_act at that wrap.
  - Load during reset is ignored.
- en and load in the same cycle: both take effect, per the rules above.
- Period 2 with PW>=2: clk_out alternates 1,0.
- Counter arithmetic is unsigned WIDTH bits; cnt never exceeds per_act-1.

Decomposition:
- Timing constants (T_100ms etc.) live in the shared mdivider.vh header. Add T_1ms and T_10ms there if they are absent.
- State encoding (IDLE=0, RUN=1, DONE=2) is a set of localparams in the module.
- The block is a single module; no sub-module is natural.

Test Plan:
All cases use M_DEFAULT=5, PW=1 unless stated otherwise.
1. Reset, then en=1 at cycle 0 -> clk_out high at cycles 1, 6, 11; wrap high at cycles 5, 10; pulses=2 after cycle 10.
2. PW=3, load period_in=4 in IDLE, en=1 -> clk_out pattern 1,1,1,0 repeating. Then PW=5 with period 4 -> 1,1,1,0 (pw_eff clamped to 3).
3. While running at period 5, load period_in=8 at cnt=2 -> the current period completes at 5 cycles and the following periods last 8 cycles. Load coinciding with wrap -> the next period is already 8.
4. oneshot=1, en=1 -> exactly one clk_out pulse and one wrap. done=1 from cycle 5 onward. en 0->1 -> a new single period starts.
5. load period_in=0 and period_in=1 -> behaves as period 2: clk_out 1,0,1,0.
6. rstn pulsed low mid-period, asynchronously between edges -> outputs go to 0 immediately and per_act returns to 5. With en held high, pulses restart from 0 after release.

Source files
------------

// File: rtl/mdivider_prog_pkg.sv
// mdivider_prog_pkg: shared definitions for the programmable pulse divider.
//   - Timing constants in system-clock cycles (12 MHz iceStick clock).
//   - FSM state type, also exported on the divider's debug port.
package mdivider_prog_pkg;

    localparam int unsigned CLK_HZ  = 12_000_000;
    localparam int unsigned T_1MS   = 12_000;
    localparam int unsigned T_10MS  = 120_000;
    localparam int unsigned T_100MS = 1_200_000;

    // Encoding is fixed: IDLE=0, RUN=1, DONE=2.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mdivider_prog.sv
// mdivider_prog: runtime-programmable pulse divider.
// Counts clk cycles modulo a loadable period and emits a registered pulse
// train with a parametrised high time, periodic or one-shot.
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   en         in   level: 1 = run, 0 = stop, clear counter and outputs
//   oneshot    in   sampled when leaving IDLE: 1 = single period then DONE
//   load       in   1-cycle strobe, captures period_in
//   period_in  in   new period in clk cycles (values < 2 are stored as 2)
//   clk_out    out  registered pulse output
//   wrap       out  registered strobe, high in the last cycle of each period
//   done       out  high while in DONE
//   pulses     out  completed periods since leaving IDLE, modulo 2^CW
//   state_dbg  out  current FSM state
//
// Control semantics: en is a level and load a single-cycle strobe; there is
// no back-pressure. Both are sampled on every rising clk edge and both take
// effect when asserted in the same cycle. A load outside RUN updates the
// active period at once; a load in RUN updates only the shadow period,
// which becomes active at the next wrap (a load in the wrap cycle itself is
// bypassed straight into that wrap), so running periods are never cut short.
module mdivider_prog
    import mdivider_prog_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned M_DEFAULT = T_100MS,
    parameter int unsigned PW        = 1,
    parameter int unsigned CW        = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    output logic             clk_out,
    output logic             wrap,
    output logic             done,
    output logic [CW-1:0]    pulses,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] PW_W    = WIDTH'(PW);
    localparam logic [WIDTH-1:0] PER_RST = WIDTH'(M_DEFAULT);
    localparam logic [WIDTH-1:0] PER_MIN = WIDTH'(2);

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] per_act_q;
    logic [WIDTH-1:0] per_shd_q;
    logic             mode_q;
    logic             clk_out_q;
    logic             wrap_q;
    logic             done_q;
    logic [CW-1:0]    pulses_q;

    logic [WIDTH-1:0] last_d;
    logic [WIDTH-1:0] pw_eff_d;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] per_in_d;
    logic [WIDTH-1:0] per_next_d;
    logic             at_last_d;
    logic             wrap_d;

    always_comb begin
        last_d     = per_act_q - WIDTH'(1);
        // High time is capped so every period keeps at least one low cycle.
        pw_eff_d   = (PW_W < last_d) ? PW_W : last_d;
        at_last_d  = (cnt_q == last_d);
        cnt_d      = at_last_d ? '0 : cnt_q + WIDTH'(1);
        wrap_d     = (cnt_d == last_d);
        per_in_d   = (period_in < PER_MIN) ? PER_MIN : period_in;
        // Period that becomes active at a wrap: a load in the same cycle wins.
        per_next_d = load ? per_in_d : per_shd_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_act_q <= PER_RST;
            per_shd_q <= PER_RST;
            mode_q    <= 1'b0;
            clk_out_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            pulses_q  <= '0;
        end else begin
            if (load) begin
                per_shd_q <= per_in_d;
                if (state_q != ST_RUN) begin
                    per_act_q <= per_in_d;
                end
            end

            if (!en) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                clk_out_q <= 1'b0;
                wrap_q    <= 1'b0;
                done_q    <= 1'b0;
                pulses_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // First pulse starts on the same edge that leaves IDLE.
                        state_q   <= ST_RUN;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b1;
                        wrap_q    <= 1'b0;
                        done_q    <= 1'b0;
                        mode_q    <= oneshot;
                    end
                    ST_RUN: begin
                        cnt_q <= cnt_d;
                        if (at_last_d) begin
                            per_act_q <= per_next_d;
                            pulses_q  <= pulses_q + CW'(1);
                        end
                        if (mode_q && wrap_d) begin
                            // One-shot ends in its wrap cycle: the strobe and
                            // done are raised together and the period counts.
                            state_q   <= ST_DONE;
                            cnt_q     <= '0;
                            per_act_q <= per_next_d;
                            pulses_q  <= pulses_q + CW'(1);
                            clk_out_q <= 1'b0;
                            wrap_q    <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            clk_out_q <= (cnt_d < pw_eff_d);
                            wrap_q    <= wrap_d;
                        end
                    end
                    ST_DONE: begin
                        cnt_q     <= '0;
                        clk_out_q <= 1'b0;
                        wrap_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b0;
                        wrap_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign clk_out   = clk_out_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign pulses    = pulses_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mdivider_prog.sv
// tb_mdivider_prog: directed bench for mdivider_prog.
// Three instances share one stimulus stream: M_DEFAULT=5 with PW=1, 3, 5.
// A period-position model predicts every output each cycle; hand-computed
// cycle patterns pin the model for the main scenarios.
module tb_mdivider_prog;
    import mdivider_prog_pkg::*;

    localparam int N  = 3;
    localparam int MD = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        oneshot = 1'b0;
    logic        load = 1'b0;
    logic [23:0] period_in = '0;

    logic        clk_out_w [N];
    logic        wrap_w    [N];
    logic        done_w    [N];
    logic [15:0] pulses_w  [N];
    state_t      dbg_w     [N];

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mdivider_prog #(
            .WIDTH(24), .M_DEFAULT(MD), .PW(2 * g + 1), .CW(16)
        ) u_dut (
            .clk(clk), .rstn(rstn), .en(en), .oneshot(oneshot), .load(load),
            .period_in(period_in), .clk_out(clk_out_w[g]), .wrap(wrap_w[g]),
            .done(done_w[g]), .pulses(pulses_w[g]), .state_dbg(dbg_w[g])
        );
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // m_st: 0 idle, 1 running, 2 finished one-shot. m_pos: position of the
    // current output cycle within its period.
    int m_st [N], m_pos [N], m_pa [N], m_ps [N], m_pul [N], m_osh [N], m_wr [N];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_pos[i] = 0; m_pa[i] = MD; m_ps[i] = MD;
            m_pul[i] = 0; m_osh[i] = 0; m_wr[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int st0;
        int p;
        p = (period_in < 2) ? 2 : int'(period_in);
        for (int i = 0; i < N; i++) begin
            st0 = m_st[i];
            m_wr[i] = 0;
            if (load) begin
                m_ps[i] = p;
                if (st0 != 1) m_pa[i] = p;
            end
            if (!en) begin
                m_st[i] = 0; m_pos[i] = 0; m_pul[i] = 0;
            end else if (st0 == 0) begin
                m_st[i] = 1; m_pos[i] = 0; m_osh[i] = int'(oneshot);
            end else if (st0 == 1) begin
                if (m_pos[i] == m_pa[i] - 1) begin
                    m_pos[i] = 0; m_pa[i] = m_ps[i]; m_pul[i]++;
                end else begin
                    m_pos[i]++;
                    if (m_pos[i] == m_pa[i] - 1) begin
                        m_wr[i] = 1;
                        if (m_osh[i] != 0) begin
                            m_st[i] = 2; m_pul[i]++; m_pa[i] = m_ps[i];
                        end
                    end
                end
            end
        end
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_reset();
        else model_step();
    end

    // ---------------- scoreboard: every cycle out of reset ----------------
    always @(posedge clk) begin
        #1;
        if (rstn) begin
            for (int i = 0; i < N; i++) begin
                int pw_eff;
                logic exp_clk;
                pw_eff  = (2 * i + 1 < m_pa[i] - 1) ? 2 * i + 1 : m_pa[i] - 1;
                exp_clk = (m_st[i] == 1) && (m_pos[i] < pw_eff);
                check($sformatf("u%0d.clk_out t=%0t", i, $time), 64'(clk_out_w[i]), 64'(exp_clk));
                check($sformatf("u%0d.wrap t=%0t", i, $time), 64'(wrap_w[i]), 64'(m_wr[i]));
                check($sformatf("u%0d.done t=%0t", i, $time), 64'(done_w[i]), 64'(m_st[i] == 2));
                check($sformatf("u%0d.pulses t=%0t", i, $time), 64'(pulses_w[i]), 64'(m_pul[i] % 65536));
                check($sformatf("u%0d.state t=%0t", i, $time), 64'(dbg_w[i]), 64'(m_st[i]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_idle(input int p);
        en = 1'b0;
        tick();
        load = 1'b1; period_in = 24'(p);
        tick();
        load = 1'b0;
    endtask

    logic [63:0] h_clk [N];
    logic [63:0] h_wrap;
    logic [63:0] h_done;

    task automatic clear_hist();
        for (int i = 0; i < N; i++) h_clk[i] = '0;
        h_wrap = '0;
        h_done = '0;
    endtask

    task automatic record(input int c);
        for (int i = 0; i < N; i++) h_clk[i][c] = clk_out_w[i];
        h_wrap[c] = wrap_w[0];
        h_done[c] = done_w[0];
    endtask

    initial begin
        tick();
        tick();
        // Reset state, still in reset.
        check("rst clk_out", 64'(clk_out_w[0]), 64'd0);
        check("rst pulses", 64'(pulses_w[2]), 64'd0);
        check("rst state", 64'(dbg_w[1]), 64'(ST_IDLE));
        rstn = 1'b1;
        tick();

        // 1: periodic at the default period 5.
        clear_hist();
        en = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            record(c);
        end
        check("t1 clk_out", h_clk[0], 64'h842);
        check("t1 wrap", h_wrap, 64'h420);
        check("t1 pulses", 64'(pulses_w[0]), 64'd2);

        // 2: load 4 in IDLE together with en; PW 3 and 5 both give 1,1,1,0.
        en = 1'b0;
        tick();
        clear_hist();
        en = 1'b1; load = 1'b1; period_in = 24'd4;
        for (int c = 1; c <= 8; c++) begin
            tick();
            load = 1'b0;
            record(c);
        end
        check("t2 pw1", h_clk[0], 64'h22);
        check("t2 pw3", h_clk[1], 64'hEE);
        check("t2 pw5 clamp", h_clk[2], 64'hEE);
        load_idle(5);

        // 3: load 8 mid-period, then load 3 in a wrap cycle (bypass).
        clear_hist();
        en = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            load = 1'b0;
            record(c);
            if (c == 3)  begin load = 1'b1; period_in = 24'd8; end
            if (c == 29) begin load = 1'b1; period_in = 24'd3; end
        end
        check("t3 wrap", h_wrap, 64'h0000_0009_2020_2020);
        load_idle(5);

        // 4: one-shot, then restart.
        clear_hist();
        oneshot = 1'b1; en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            record(c);
        end
        check("t4 clk_out", h_clk[0], 64'h2);
        check("t4 wrap", h_wrap, 64'h20);
        check("t4 done", h_done, 64'h1E0);
        check("t4 pulses", 64'(pulses_w[0]), 64'd1);
        en = 1'b0;
        tick();
        clear_hist();
        en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            record(c);
        end
        check("t4 restart done", h_done, 64'h60);
        oneshot = 1'b0;

        // 5: period 0 and period 1 clamp to 2.
        load_idle(0);
        clear_hist();
        en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            record(c);
        end
        check("t5 p0 pw5", h_clk[2], 64'h2A);
        check("t5 p0 wrap", h_wrap, 64'h54);
        en = 1'b0;
        tick();
        clear_hist();
        en = 1'b1; load = 1'b1; period_in = 24'd1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            load = 1'b0;
            record(c);
        end
        check("t5 p1 pw1", h_clk[0], 64'h2A);
        check("t5 p1 pw3", h_clk[1], 64'h2A);

        // 6: async reset mid-period at period 3; default period returns.
        load_idle(3);
        en = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        check("t6 pre clk_out", 64'(clk_out_w[0]), 64'd1);
        check("t6 pre pulses", 64'(pulses_w[0]), 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("t6 async clk_out", 64'(clk_out_w[0]), 64'd0);
        check("t6 async pulses", 64'(pulses_w[0]), 64'd0);
        check("t6 async state", 64'(dbg_w[0]), 64'(ST_IDLE));
        #1 rstn = 1'b1;
        clear_hist();
        for (int c = 1; c <= 11; c++) begin
            tick();
            record(c);
            if (c == 1) check("t6 pulses restart", 64'(pulses_w[0]), 64'd0);
        end
        check("t6 clk_out", h_clk[0], 64'h842);
        check("t6 wrap", h_wrap, 64'h420);
        check("t6 pulses", 64'(pulses_w[0]), 64'd2);

        en = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
